// File: rtl/dec_2_92_batch32_pkg.sv
// Shared definitions for the 4->92 dense decoder: Q8.8 constants, FSM states, batch math.
package dec_2_92_batch32_pkg;
    localparam int BITSIZE = 16;
    localparam int FRAC_BITS = 8;
    localparam logic [BITSIZE-1:0] ONE = 16'h0100;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FINISH
    } state_t;

    function automatic int batch_count(input int out_size, input int batch);
        return (out_size + batch - 1) / batch;
    endfunction
endpackage

// File: rtl/dec_2_92_batch32_lane.sv
// One decoder lane: IN_SIZE multipliers, product register, bias + wrapped sum.
// Build macro DEC_RELU_EN clamps negative sums to zero.
module dec_lane #(
    parameter int BITSIZE = 16,
    parameter int IN_SIZE = 4
) (
    input  logic                       clk,
    input  logic                       load,
    input  logic [BITSIZE*IN_SIZE-1:0] x,
    input  logic [BITSIZE*IN_SIZE-1:0] w,
    input  logic [BITSIZE-1:0]         bias,
    output logic [BITSIZE-1:0]         sum
);
    import dec_2_92_batch32_pkg::*;

    logic signed [BITSIZE-1:0] prod    [IN_SIZE];
    logic signed [BITSIZE-1:0] prod_p1 [IN_SIZE];
    logic signed [BITSIZE-1:0] acc;

    function automatic logic signed [BITSIZE-1:0] relu(input logic signed [BITSIZE-1:0] v);
`ifdef DEC_RELU_EN
        return v[BITSIZE-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    for (genvar i = 0; i < IN_SIZE; i++) begin : g_mul
        fixed_point_multiply #(
            .BITSIZE  (BITSIZE),
            .FRAC_BITS(FRAC_BITS)
        ) u_mul (
            .a(x[i*BITSIZE +: BITSIZE]),
            .b(w[i*BITSIZE +: BITSIZE]),
            .p(prod[i])
        );
    end

    // Stage 1: product register
    always_ff @(posedge clk) begin
        if (load) prod_p1 <= prod;
    end

    // Stage 2 operand: bias plus products, wrapping modulo 2^BITSIZE
    always_comb begin
        acc = bias;
        for (int i = 0; i < IN_SIZE; i++) acc = acc + prod_p1[i];
        sum = relu(acc);
    end
endmodule

// File: rtl/fixed_point_multiply.sv
// Signed fixed-point multiply: full-width product shifted back down by FRAC_BITS, wrapped to BITSIZE.
module fixed_point_multiply #(
    parameter int BITSIZE   = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic signed [BITSIZE-1:0] a,
    input  logic signed [BITSIZE-1:0] b,
    output logic signed [BITSIZE-1:0] p
);
    logic signed [2*BITSIZE-1:0] full;

    assign full = a * b;
    assign p    = BITSIZE'(full >>> FRAC_BITS);
endmodule

// File: rtl/dec_2_92_batch32.sv
// Dense decoder 4 -> 92, BATCH neurons per cycle, start/busy/done handshake.
// Build macro DEC_RELU_EN enables the output ReLU inside each lane.
module dec_2_92_batch32 #(
    parameter int BITSIZE  = 16,
    parameter int IN_SIZE  = 4,
    parameter int OUT_SIZE = 92,
    parameter int BATCH    = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [BITSIZE*IN_SIZE-1:0]          x,
    input  logic [BITSIZE*OUT_SIZE*IN_SIZE-1:0] w,
    input  logic [BITSIZE*OUT_SIZE-1:0]         b,
    output logic [BITSIZE*OUT_SIZE-1:0]         y,
    output logic                                busy,
    output logic                                done
);
    import dec_2_92_batch32_pkg::*;

    localparam int BATCH_COUNT = batch_count(OUT_SIZE, BATCH);
    localparam int BIDX_W      = (BATCH_COUNT > 1) ? $clog2(BATCH_COUNT + 1) : 1;
    localparam int LANE_W      = BITSIZE * IN_SIZE;
    localparam logic [BIDX_W-1:0] LAST = BIDX_W'(BATCH_COUNT - 1);

    state_t              state, state_d;
    logic                run_en, accept;
    logic [BIDX_W-1:0]   batch_idx, batch_p1;
    logic                vld_p1;
    logic [LANE_W-1:0]   x_q;
    logic [LANE_W-1:0]   w_cand   [BATCH_COUNT][BATCH];
    logic [BITSIZE-1:0]  b_cand   [BATCH_COUNT][BATCH];
    logic [LANE_W-1:0]   w_sel    [BATCH];
    logic [BITSIZE-1:0]  b_sel    [BATCH];
    logic [BITSIZE-1:0]  lane_sum [BATCH];
    logic [BITSIZE-1:0]  y_p2     [OUT_SIZE];

    // Slots past OUT_SIZE see zero weights so their products are zero
    for (genvar k = 0; k < BATCH_COUNT; k++) begin : g_batch
        for (genvar l = 0; l < BATCH; l++) begin : g_slot
            if (k * BATCH + l < OUT_SIZE) begin : g_live
                assign w_cand[k][l] = w[(k*BATCH+l)*LANE_W +: LANE_W];
                assign b_cand[k][l] = b[(k*BATCH+l)*BITSIZE +: BITSIZE];
            end else begin : g_pad
                assign w_cand[k][l] = '0;
                assign b_cand[k][l] = '0;
            end
        end
    end

    always_comb begin
        for (int l = 0; l < BATCH; l++) begin
            w_sel[l] = '0;
            b_sel[l] = '0;
            for (int k = 0; k < BATCH_COUNT; k++) begin
                if (batch_idx == BIDX_W'(k)) w_sel[l] = w_cand[k][l];
                if (batch_p1 == BIDX_W'(k))  b_sel[l] = b_cand[k][l];
            end
        end
    end

    for (genvar l = 0; l < BATCH; l++) begin : g_lane
        dec_lane #(
            .BITSIZE(BITSIZE),
            .IN_SIZE(IN_SIZE)
        ) u_lane (
            .clk (clk),
            .load(run_en),
            .x   (x_q),
            .w   (w_sel[l]),
            .bias(b_sel[l]),
            .sum (lane_sum[l])
        );
    end

    always_comb begin
        state_d = state;
        run_en  = 1'b0;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                run_en = 1'b1;
                if (batch_idx == LAST) state_d = DRAIN;
            end
            DRAIN:   state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            batch_idx <= '0;
            batch_p1  <= '0;
            vld_p1    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state  <= state_d;
            vld_p1 <= run_en;
            done   <= (state == DRAIN);
            if (run_en) begin
                batch_p1  <= batch_idx;
                batch_idx <= batch_idx + 1'b1;
            end
            if (accept) begin
                batch_idx <= '0;
                busy      <= 1'b1;
            end
            if (state == FINISH) busy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) x_q <= x;
    end

    // Stage 2: commit lane sums of the registered batch into y
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int o = 0; o < OUT_SIZE; o++) y_p2[o] <= '0;
        end else if (vld_p1) begin
            for (int o = 0; o < OUT_SIZE; o++) begin
                if (batch_p1 == BIDX_W'(o / BATCH)) y_p2[o] <= lane_sum[o % BATCH];
            end
        end
    end

    for (genvar o = 0; o < OUT_SIZE; o++) begin : g_y
        assign y[o*BITSIZE +: BITSIZE] = y_p2[o];
    end
endmodule

// File: tb/tb_dec_2_92_batch32.sv
// Scoreboard bench for dec_2_92_batch32: directed test-plan cases plus randomized runs.
module tb_dec_2_92_batch32;
    localparam int BITSIZE  = 16;
    localparam int IN_SIZE  = 4;
    localparam int OUT_SIZE = 92;
    localparam int BATCH    = 32;
    localparam int YW       = BITSIZE * OUT_SIZE;

    logic                                clk = 1'b0;
    logic                                reset;
    logic                                start;
    logic [BITSIZE*IN_SIZE-1:0]          x;
    logic [BITSIZE*OUT_SIZE*IN_SIZE-1:0] w;
    logic [YW-1:0]                       b;
    logic [YW-1:0]                       y;
    logic                                busy;
    logic                                done;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [YW-1:0] exp_q[$];
    logic [YW-1:0] last_exp;
    logic [YW-1:0] mon_e;
    int            bad;

    always #5 clk = ~clk;

    dec_2_92_batch32 #(
        .BITSIZE (BITSIZE),
        .IN_SIZE (IN_SIZE),
        .OUT_SIZE(OUT_SIZE),
        .BATCH   (BATCH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .x    (x),
        .w    (w),
        .b    (b),
        .y    (y),
        .busy (busy),
        .done (done)
    );

    // Q8.8 multiply as real-number arithmetic: exact product, floor-divide by 256, keep 16 bits
    function automatic logic [15:0] fpm(input logic [15:0] a, input logic [15:0] c);
        int p;
        p = $signed(a) * $signed(c);
        return 16'(p >>> 8);
    endfunction

    function automatic logic [YW-1:0] model();
        logic [YW-1:0] r;
        logic [15:0]   acc;
        for (int o = 0; o < OUT_SIZE; o++) begin
            acc = b[o*16 +: 16];
            for (int i = 0; i < IN_SIZE; i++)
                acc = acc + fpm(x[i*16 +: 16], w[(o*IN_SIZE+i)*16 +: 16]);
`ifdef DEC_RELU_EN
            if (acc[15]) acc = 16'h0000;
`endif
            r[o*16 +: 16] = acc;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_all(input logic [15:0] xv, input logic [15:0] wv, input logic [15:0] bv);
        for (int i = 0; i < IN_SIZE; i++) x[i*16 +: 16] = xv;
        for (int o = 0; o < OUT_SIZE; o++) begin
            b[o*16 +: 16] = bv;
            for (int i = 0; i < IN_SIZE; i++) w[(o*IN_SIZE+i)*16 +: 16] = wv;
        end
    endtask

    task automatic randomize_all();
        for (int i = 0; i < IN_SIZE; i++) x[i*16 +: 16] = 16'($urandom);
        for (int o = 0; o < OUT_SIZE; o++) begin
            b[o*16 +: 16] = 16'($urandom);
            for (int i = 0; i < IN_SIZE; i++) w[(o*IN_SIZE+i)*16 +: 16] = 16'($urandom);
        end
    endtask

    // mode 1: start re-pulsed at E1 and E2, x scrambled after acceptance, progressive update checked
    task automatic run(input string name, input int mode);
        int            lat;
        logic [YW-1:0] e;
        e = model();
        exp_q.push_back(e);
        start = 1'b1;
        @(posedge clk);
        #1;
        check({name, " busy_after_start"}, busy, 1);
        if (mode == 1) x = {$urandom, $urandom};
        else start = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            if (lat == 2) begin
                #1;
                start = 1'b0;
            end
            @(negedge clk);
            if (mode == 1 && lat == 1) check({name, " y_hold_E1"}, y == last_exp, 1);
            if (mode == 1 && lat == 2)
                check({name, " batch0_E2"}, y[BATCH*16-1:0] == e[BATCH*16-1:0], 1);
            if (done) break;
        end
        check({name, " latency"}, lat, 4);
        last_exp = e;
        @(posedge clk);
        @(negedge clk);
        check({name, " done_pulse_width"}, done, 0);
        check({name, " busy_cleared"}, busy, 0);
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL done_unexpected: got done=1, expected done=0 (no run outstanding)");
            end else begin
                mon_e = exp_q.pop_front();
                if (y !== mon_e) begin
                    miscompares++;
                    bad = 0;
                    for (int o = OUT_SIZE - 1; o >= 0; o--)
                        if (y[o*16 +: 16] !== mon_e[o*16 +: 16]) bad = o;
                    $display("FAIL y[%0d]: got 0x%04h, expected 0x%04h", bad, y[bad*16 +: 16],
                             mon_e[bad*16 +: 16]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        x     = '0;
        w     = '0;
        b     = '0;
        last_exp = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset y_zero", y == '0, 1);

        set_all(16'h0100, 16'h0100, 16'h0000);
        run("unit", 0);
        check("unit y0", y[15:0], 16'h0400);
        check("unit y91", y[91*16 +: 16], 16'h0400);

        set_all(16'h0000, 16'h0100, 16'h0000);
        for (int o = 0; o < OUT_SIZE; o++) b[o*16 +: 16] = 16'(o);
        run("bias", 0);
        check("bias y88", y[88*16 +: 16], 88);
        check("bias y91", y[91*16 +: 16], 91);

        set_all(16'h0000, 16'h0000, 16'h0000);
        x[16 +: 16] = 16'h0180;
        for (int o = 0; o < OUT_SIZE; o++) w[(o*IN_SIZE+1)*16 +: 16] = 16'h0200;
        run("single", 0);
        check("single y45", y[45*16 +: 16], 16'h0300);

        randomize_all();
        run("rand_pre", 0);
        randomize_all();
        run("retrigger", 1);

        randomize_all();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrun_reset y_zero", y == '0, 1);
        check("midrun_reset busy", busy, 0);
        check("midrun_reset done", done, 0);
        repeat (8) @(negedge clk);
        last_exp = '0;
        run("post_reset", 0);

        set_all(16'h0000, 16'h0000, 16'h0000);
        x[15:0] = 16'hFF00;
        for (int o = 0; o < OUT_SIZE; o++) w[(o*IN_SIZE)*16 +: 16] = 16'h0100;
        run("negative", 0);
`ifdef DEC_RELU_EN
        check("negative y0", y[15:0], 16'h0000);
`else
        check("negative y0", y[15:0], 16'hFF00);
`endif

        set_all(16'h0000, 16'h0000, 16'h7F00);
        x[15:0] = 16'h0100;
        for (int o = 0; o < OUT_SIZE; o++) w[(o*IN_SIZE)*16 +: 16] = 16'h0200;
        run("wrap", 0);
`ifdef DEC_RELU_EN
        check("wrap y91", y[91*16 +: 16], 16'h0000);
`else
        check("wrap y91", y[91*16 +: 16], 16'h8100);
`endif

        for (int n = 0; n < 15; n++) begin
            randomize_all();
            run("random", 0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
